// File: rtl/write_pointer_ctrl_if.sv
// Write-side bundle of the async FIFO: write request and synchronized read pointer in,
// Gray write pointer, RAM write port and flag/diagnostic outputs out.
interface write_pointer_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DROP_W     = 8
);
  logic                  inc_i;
  logic [ADDR_WIDTH:0]   wq2_rptr_i;
  logic                  clr_ovf_i;
  logic [ADDR_WIDTH:0]   wptr_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic                  wclken_o;
  logic                  full_o;
  logic                  almost_full_o;
  logic [ADDR_WIDTH:0]   wlevel_o;
  logic                  overflow_o;
  logic [DROP_W-1:0]     drop_cnt_o;

  modport slave (
    input  inc_i, wq2_rptr_i, clr_ovf_i,
    output wptr_o, waddr_o, wclken_o, full_o, almost_full_o, wlevel_o, overflow_o, drop_cnt_o
  );

  modport master (
    output inc_i, wq2_rptr_i, clr_ovf_i,
    input  wptr_o, waddr_o, wclken_o, full_o, almost_full_o, wlevel_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/write_pointer_ctrl.sv
// Async FIFO write-domain pointer manager: binary/Gray write pointer, RAM write port,
// full/almost_full/level flags and overflow diagnostics (sticky flag + saturating drop count).
module write_pointer_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int AF_MARGIN  = 4,
  parameter int DROP_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  write_pointer_ctrl_if.slave  wif
);
  localparam int         A      = ADDR_WIDTH;
  localparam int         DEPTH  = 1 << A;
  localparam logic [A:0] AF_THR = (A+1)'(DEPTH - AF_MARGIN);

  logic [A:0]        wbin_q, wbin_d;
  logic [A:0]        wgray_q, wgray_d;
  logic [A:0]        wlevel_q, wlevel_d;
  logic [A:0]        rbin, full_cmp;
  logic              full_q, full_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              acc, err;

  assign acc = wif.inc_i & ~full_q;
  assign err = wif.inc_i &  full_q;

  // Read pointer back to binary so the writer can report its own fill level.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= A; i++) rbin[i] = ^(wif.wq2_rptr_i >> i);
  end

  // Full: writer is exactly one lap ahead -> top two Gray bits inverted, rest equal.
  assign full_cmp = {~wif.wq2_rptr_i[A:A-1], wif.wq2_rptr_i[A-2:0]};

  always_comb begin
    wbin_d   = wbin_q + {{A{1'b0}}, acc};
    wgray_d  = (wbin_d >> 1) ^ wbin_d;
    full_d   = (wgray_d == full_cmp);
    wlevel_d = wbin_d - rbin;
    af_d     = (wlevel_d >= AF_THR);
  end

  // A rejected write in the same cycle as a clear wins: the flag stays set and counts one.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (err) begin
      ovf_d = 1'b1;
      if (wif.clr_ovf_i)    drop_d = {{(DROP_W-1){1'b0}}, 1'b1};
      else if (drop_q != '1) drop_d = drop_q + 1'b1;
    end else if (wif.clr_ovf_i) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      wlevel_q <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      full_q   <= full_d;
      af_q     <= af_d;
      wlevel_q <= wlevel_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  assign wif.wptr_o        = wgray_q;
  assign wif.waddr_o       = wbin_q[A-1:0];
  assign wif.wclken_o      = acc;
  assign wif.full_o        = full_q;
  assign wif.almost_full_o = af_q;
  assign wif.wlevel_o      = wlevel_q;
  assign wif.overflow_o    = ovf_q;
  assign wif.drop_cnt_o    = drop_q;
endmodule
